// File: rtl/player_physics.sv
// Vertical flap/gravity physics for the player sprite, stepped once per frame.
// Outputs are registered and only move on frame_tick, so they stay stable across the visible frame.
module player_physics #(
   parameter int PLAYER_X      = 200,
   parameter int PLAYER_SIZE_Y = 24,
   parameter int START_Y       = 200,
   parameter int CEIL_Y        = 0,
   parameter int FLOOR_Y       = 418,
   parameter int GRAVITY       = 1,
   parameter int FLAP_VEL      = 8,
   parameter int MAX_FALL      = 10
) (
   input  logic        VGA_clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        flap,
   input  logic [3:0]  game_state,
   output logic [15:0] playerX,
   output logic [15:0] playerY,
   output logic [3:0]  player_state,
   output logic        player_dir,
   output logic        hit
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_RISING  = 4'd1,
      S_FALLING = 4'd2,
      S_DEAD    = 4'd3
   } pstate_t;

   localparam logic [15:0]        START16 = 16'(START_Y);
   localparam logic [15:0]        CEIL16  = 16'(CEIL_Y);
   localparam logic [15:0]        REST16  = 16'(FLOOR_Y - PLAYER_SIZE_Y);
   localparam logic signed [16:0] CEIL17  = 17'(CEIL_Y);
   localparam logic signed [16:0] FLOOR17 = 17'(FLOOR_Y);
   localparam logic signed [16:0] SIZE17  = 17'(PLAYER_SIZE_Y);
   localparam logic signed [8:0]  GRAV9   = 9'(GRAVITY);
   localparam logic signed [8:0]  MAXF9   = 9'(MAX_FALL);
   localparam logic signed [7:0]  FLAP8   = 8'(-FLAP_VEL);

   pstate_t            state_q, state_d;
   logic [15:0]        y_q, y_d;
   logic signed [7:0]  vel_q, vel_d;
   logic               flap_req_q, flap_req_d;
   logic               flap_prev_q;
   logic               hit_q, hit_d;

   logic               flap_edge;
   logic               do_update;
   logic               req_now;
   logic signed [8:0]  vel_inc;
   logic signed [7:0]  new_vel;
   logic signed [16:0] new_y;

   always_ff @(posedge VGA_clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         y_q         <= START16;
         vel_q       <= '0;
         flap_req_q  <= 1'b0;
         flap_prev_q <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         vel_q       <= vel_d;
         flap_req_q  <= flap_req_d;
         flap_prev_q <= flap;
         hit_q       <= hit_d;
      end
   end

   // A flap edge landing on the tick cycle is folded straight into that update.
   always_comb begin
      flap_edge = flap & ~flap_prev_q;
      req_now   = flap_req_q | flap_edge;
      do_update = frame_tick && (game_state == 4'd1) && (state_q != S_DEAD);

      vel_inc = $signed({vel_q[7], vel_q}) + GRAV9;
      if (req_now)
         new_vel = FLAP8;
      else if (vel_inc > MAXF9)
         new_vel = MAXF9[7:0];
      else
         new_vel = vel_inc[7:0];

      new_y = $signed({1'b0, y_q}) + $signed({{9{new_vel[7]}}, new_vel});
   end

   always_comb begin
      state_d    = state_q;
      y_d        = y_q;
      vel_d      = vel_q;
      flap_req_d = req_now;
      hit_d      = 1'b0;

      if (game_state == 4'd0) begin
         state_d    = S_IDLE;
         y_d        = START16;
         vel_d      = '0;
         flap_req_d = 1'b0;
      end else if (do_update) begin
         flap_req_d = 1'b0;
         if (new_y < CEIL17) begin
            y_d     = CEIL16;
            vel_d   = '0;
            state_d = S_FALLING;
         end else if ((new_y + SIZE17) >= FLOOR17) begin
            y_d     = REST16;
            vel_d   = '0;
            state_d = S_DEAD;
            hit_d   = 1'b1;
         end else begin
            y_d     = new_y[15:0];
            vel_d   = new_vel;
            state_d = new_vel[7] ? S_RISING : S_FALLING;
         end
      end
   end

   assign playerX      = 16'(PLAYER_X);
   assign playerY      = y_q;
   assign player_state = state_q;
   assign player_dir   = vel_q[7];
   assign hit          = hit_q;

endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics: the driver queues hand-computed results,
// a negedge monitor pops and compares after every frame tick or explicit check.
module tb_player_physics;

   localparam int W  = 38;
   localparam int PX = 200;

   logic        VGA_clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic        flap;
   logic [3:0]  game_state;
   logic [15:0] playerX;
   logic [15:0] playerY;
   logic [3:0]  player_state;
   logic        player_dir;
   logic        hit;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_vec  = 0;
   int           n_fail = 0;
   logic         tick_at_edge = 1'b0;
   logic         check_req    = 1'b0;

   player_physics dut (
      .VGA_clk      (VGA_clk),
      .rst          (rst),
      .frame_tick   (frame_tick),
      .flap         (flap),
      .game_state   (game_state),
      .playerX      (playerX),
      .playerY      (playerY),
      .player_state (player_state),
      .player_dir   (player_dir),
      .hit          (hit)
   );

   always #5 VGA_clk = ~VGA_clk;

   always @(posedge VGA_clk) tick_at_edge = frame_tick;

   always @(negedge VGA_clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      a = {playerX, playerY, player_state, player_dir, hit};
      if (tick_at_edge || check_req) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got y=%0d st=%0d, nothing expected", playerY, player_state);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (a !== e) begin
               n_fail++;
               $display("FAIL %s: got x=%0d y=%0d st=%0d dir=%0d hit=%0d, want x=%0d y=%0d st=%0d dir=%0d hit=%0d",
                        nm, a[37:22], a[21:6], a[5:2], a[1], a[0],
                        e[37:22], e[21:6], e[5:2], e[1], e[0]);
            end
         end
      end else begin
         n_vec++;
         if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_idle: got hit=%b, want 0 outside the cycle after a tick", hit);
         end
      end
   end

   function automatic logic [W-1:0] mk(input int y, input int st, input bit d, input bit h);
      return {16'(PX), 16'(y), 4'(st), d, h};
   endfunction

   task automatic step();
      @(posedge VGA_clk);
      #1;
   endtask

   task automatic expect_v(input string nm, input int y, input int st, input bit d, input bit h);
      exp_q.push_back(mk(y, st, d, h));
      name_q.push_back(nm);
   endtask

   task automatic tick(input string nm, input int y, input int st, input bit d, input bit h);
      frame_tick = 1'b1;
      expect_v(nm, y, st, d, h);
      step();
      frame_tick = 1'b0;
      step();
   endtask

   task automatic tick_flap(input string nm, input int y, input int st, input bit d, input bit h);
      flap       = 1'b1;
      frame_tick = 1'b1;
      expect_v(nm, y, st, d, h);
      step();
      flap       = 1'b0;
      frame_tick = 1'b0;
      step();
   endtask

   task automatic flap_edge();
      flap = 1'b1;
      step();
      flap = 1'b0;
      step();
   endtask

   task automatic check_now(input string nm, input int y, input int st, input bit d, input bit h);
      expect_v(nm, y, st, d, h);
      check_req = 1'b1;
      @(negedge VGA_clk);
      #1;
      check_req = 1'b0;
      step();
   endtask

   initial begin
      rst        = 1'b1;
      frame_tick = 1'b0;
      flap       = 1'b0;
      game_state = 4'd0;
      step();
      step();
      check_now("reset", 200, 0, 0, 0);
      rst = 1'b0;
      step();

      // Freefall from rest, then a flap at vel=+5
      game_state = 4'd1;
      step();
      tick("fall1", 201, 2, 0, 0);
      tick("fall2", 203, 2, 0, 0);
      tick("fall3", 206, 2, 0, 0);
      tick("fall4", 210, 2, 0, 0);
      tick("fall5", 215, 2, 0, 0);
      flap_edge();
      tick("flap_pending", 207, 1, 1, 0);
      tick_flap("flap_coincident", 199, 1, 1, 0);

      // Decelerate, cross zero, reach terminal velocity
      tick("up7", 192, 1, 1, 0);
      tick("up6", 186, 1, 1, 0);
      tick("up5", 181, 1, 1, 0);
      tick("up4", 177, 1, 1, 0);
      tick("up3", 174, 1, 1, 0);
      tick("up2", 172, 1, 1, 0);
      tick("up1", 171, 1, 1, 0);
      tick("vel0", 171, 2, 0, 0);
      tick("dn1", 172, 2, 0, 0);
      tick("dn2", 174, 2, 0, 0);
      tick("dn3", 177, 2, 0, 0);
      tick("dn4", 181, 2, 0, 0);
      tick("dn5", 186, 2, 0, 0);
      tick("dn6", 192, 2, 0, 0);
      tick("dn7", 199, 2, 0, 0);
      tick("dn8", 207, 2, 0, 0);
      tick("dn9", 216, 2, 0, 0);
      tick("dn10", 226, 2, 0, 0);
      tick("terminal1", 236, 2, 0, 0);
      for (int y = 246; y <= 386; y += 10)
         tick("terminal", y, 2, 0, 0);

      // Floor collision and the DEAD hold
      tick("floor_hit", 394, 3, 0, 1);
      tick("dead1", 394, 3, 0, 0);
      flap_edge();
      tick("dead2", 394, 3, 0, 0);
      tick("dead3", 394, 3, 0, 0);
      game_state = 4'd0;
      step();
      step();
      check_now("restart_idle", 200, 0, 0, 0);

      // Flap up into the ceiling
      game_state = 4'd1;
      step();
      for (int k = 1; k <= 25; k++)
         tick_flap("climb", 200 - 8 * k, 1, 1, 0);
      tick_flap("ceil_clamp", 0, 2, 0, 0);
      tick("after_ceil", 1, 2, 0, 0);

      // Pause freezes position but still latches a flap
      game_state = 4'd2;
      step();
      for (int k = 0; k < 5; k++)
         tick("pause", 1, 2, 0, 0);
      flap_edge();
      game_state = 4'd3;
      step();
      tick("win_freeze", 1, 2, 0, 0);
      game_state = 4'd1;
      step();
      tick("paused_flap", 0, 2, 0, 0);
      tick("resume1", 1, 2, 0, 0);
      tick("resume2", 3, 2, 0, 0);

      // Asynchronous reset mid-play drops the pending flap
      flap_edge();
      rst = 1'b1;
      check_now("rst_midplay", 200, 0, 0, 0);
      rst = 1'b0;
      step();
      tick("post_reset", 201, 2, 0, 0);
      step();

      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d leftover expectations, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
